// File: rtl/result_writeback.sv
// Buffers an M_ROW x M_COL result matrix from the systolic array (one column per beat)
// and writes it back element by element as single-beat AXI write transactions.
module result_writeback #(
    parameter int M_ROW = 9,
    parameter int M_COL = 9
) (
    input  logic                 M_AXI_ACLK,
    input  logic                 M_AXI_ARESETN,
    input  logic                 init_txn_pulse,
    input  logic                 res_valid,
    input  logic [M_ROW*32-1:0]  res_data,
    output logic                 res_ready,
    input  logic                 wb_start,
    input  logic [31:0]          base_addr,
    output logic [31:0]          M_AXI_AWADDR,
    output logic                 M_AXI_AWVALID,
    input  logic                 M_AXI_AWREADY,
    output logic [31:0]          M_AXI_WDATA,
    output logic [3:0]           M_AXI_WSTRB,
    output logic                 M_AXI_WVALID,
    input  logic                 M_AXI_WREADY,
    input  logic [1:0]           M_AXI_BRESP,
    input  logic                 M_AXI_BVALID,
    output logic                 M_AXI_BREADY,
    output logic                 wb_done,
    output logic                 wb_error
);
    localparam int NEL = M_ROW * M_COL;
    localparam int IW  = 8;
    localparam int RW  = (M_ROW > 1) ? $clog2(M_ROW) : 1;
    localparam int CW  = (M_COL > 1) ? $clog2(M_COL) : 1;

    typedef enum logic [2:0] {CAPTURE, FULL, WRITE, RESP, DONE} state_t;

    state_t         state, state_nxt;
    logic [31:0]    buffer [M_ROW][M_COL];
    logic [CW-1:0]  cap_col;
    logic [RW-1:0]  wr_row;
    logic [CW-1:0]  wr_col;
    logic [IW-1:0]  idx;
    logic [31:0]    base;
    logic           aw_sent, w_sent, error;
    logic           clear, cap_fire, start_fire, aw_fire, w_fire, b_fire, last_el;

    // Soft clear is honoured only where no AXI transaction is in flight.
    assign clear      = init_txn_pulse && (state == CAPTURE || state == FULL || state == DONE);
    assign cap_fire   = (state == CAPTURE) && res_valid;
    assign start_fire = (state == FULL) && wb_start;
    assign aw_fire    = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_fire     = M_AXI_WVALID && M_AXI_WREADY;
    assign b_fire     = (state == RESP) && M_AXI_BVALID;
    assign last_el    = (idx == IW'(NEL - 1));

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state <= CAPTURE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CAPTURE: begin
                if (init_txn_pulse)                                 state_nxt = CAPTURE;
                else if (cap_fire && cap_col == CW'(M_COL - 1))     state_nxt = FULL;
            end
            FULL: begin
                if (init_txn_pulse)  state_nxt = CAPTURE;
                else if (wb_start)   state_nxt = WRITE;
            end
            WRITE: begin
                if ((aw_sent || aw_fire) && (w_sent || w_fire)) state_nxt = RESP;
            end
            RESP: begin
                if (b_fire) state_nxt = last_el ? DONE : WRITE;
            end
            DONE: begin
                if (init_txn_pulse) state_nxt = CAPTURE;
            end
            default: state_nxt = CAPTURE;
        endcase
    end

    always_comb begin
        res_ready     = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        wb_done       = 1'b0;
        case (state)
            CAPTURE: res_ready = 1'b1;
            WRITE: begin
                M_AXI_AWVALID = !aw_sent;
                M_AXI_WVALID  = !w_sent;
            end
            RESP:    M_AXI_BREADY = 1'b1;
            DONE:    wb_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN || clear) begin
            for (int r = 0; r < M_ROW; r++) begin
                for (int c = 0; c < M_COL; c++) begin
                    buffer[r][c] <= '0;
                end
            end
            cap_col <= '0;
            idx     <= '0;
            wr_row  <= '0;
            wr_col  <= '0;
            aw_sent <= 1'b0;
            w_sent  <= 1'b0;
            error   <= 1'b0;
            if (!M_AXI_ARESETN) base <= '0;
        end else begin
            if (cap_fire) begin
                for (int r = 0; r < M_ROW; r++) begin
                    buffer[r][cap_col] <= res_data[(M_ROW-1-r)*32 +: 32];
                end
                cap_col <= (cap_col == CW'(M_COL - 1)) ? '0 : cap_col + CW'(1);
            end
            if (start_fire) begin
                base   <= base_addr;
                idx    <= '0;
                wr_row <= '0;
                wr_col <= '0;
            end
            if (aw_fire) aw_sent <= 1'b1;
            if (w_fire)  w_sent  <= 1'b1;
            if (b_fire) begin
                aw_sent <= 1'b0;
                w_sent  <= 1'b0;
                if (M_AXI_BRESP != 2'b00) error <= 1'b1;
                // Row/column counters track idx so no divide is needed to address the buffer.
                if (!last_el) begin
                    idx <= idx + IW'(1);
                    if (wr_col == CW'(M_COL - 1)) begin
                        wr_col <= '0;
                        wr_row <= wr_row + RW'(1);
                    end else begin
                        wr_col <= wr_col + CW'(1);
                    end
                end
            end
        end
    end

    assign M_AXI_AWADDR = base + {{(32-IW-2){1'b0}}, idx, 2'b00};
    assign M_AXI_WDATA  = buffer[wr_row][wr_col];
    assign M_AXI_WSTRB  = 4'hF;
    assign wb_error     = error;

endmodule

// File: doc/result_writeback.md
# result_writeback

Collects the output matrix of the systolic array one column per beat into an M_ROW x M_COL buffer, then writes every element back to system memory as single-beat AXI write transactions. It is the write-side counterpart of the weight-loading path, which reads matrices in over the AXI read channel. It sits between the systolic array output and the AXI master write channels (AW/W/B).

## Interface

Parameters:
- M_ROW, 9, rows of the result matrix (elements per captured beat)
- M_COL, 9, columns of the result matrix (beats per capture); M_ROW*M_COL <= 255

Ports:
- M_AXI_ACLK  in  1  sole clock, rising edge
- M_AXI_ARESETN  in  1  synchronous, active-low reset
- init_txn_pulse  in  1  soft clear of buffer and state (see Operation)
- res_valid  in  1  result column valid
- res_data  in  M_ROW*32  result column; row r at bits [(M_ROW-1-r)*32 +: 32] (row 0 in MSBs)
- res_ready  out  1  block accepts a result column
- wb_start  in  1  start writeback pulse
- base_addr  in  32  byte address of element (0,0); sampled on accepted wb_start
- M_AXI_AWADDR  out  32  write address
- M_AXI_AWVALID  out  1  address valid
- M_AXI_AWREADY  in  1  address ready
- M_AXI_WDATA  out  32  write data
- M_AXI_WSTRB  out  4  constant 4'hF
- M_AXI_WVALID  out  1  data valid
- M_AXI_WREADY  in  1  data ready
- M_AXI_BRESP  in  2  write response
- M_AXI_BVALID  in  1  response valid
- M_AXI_BREADY  out  1  response ready
- wb_done  out  1  all elements written, held until cleared
- wb_error  out  1  sticky: any BRESP != 2'b00 during this writeback

## Operation

- States: CAPTURE, FULL, WRITE, RESP, DONE.
- CAPTURE: res_ready=1. On res_valid&&res_ready, column counter c is stored: buf[r][c] <= res_data row r; c increments. After the beat with c=M_COL-1 is accepted -> FULL. wb_start in CAPTURE is ignored.
- FULL: res_ready=0; res_valid is ignored. On wb_start: latch base_addr, element index i=0 -> WRITE.
- Element order is row-major: i = r*M_COL + c; AWADDR = base_addr + (i<<2), 32-bit modulo 2^32 wrap; WDATA = buf[r][c].
- WRITE: AWVALID and WVALID assert together on entry. Each deasserts independently the cycle after its own handshake; AWADDR/WDATA remain stable while the corresponding valid is high. When both handshakes have completed (same or different cycles) -> RESP.
- RESP: BREADY=1. On BVALID: if BRESP != 0, wb_error <= 1. If i = M_ROW*M_COL-1 -> DONE, else i++ -> WRITE. Exactly one outstanding transaction.
- DONE: wb_done=1, res_ready=0, all AXI valids low, BREADY low.
- init_txn_pulse in CAPTURE, FULL or DONE: clear buffer to 0, c=0, i=0, wb_done=0, wb_error=0 -> CAPTURE. In WRITE or RESP it is ignored (no AXI valid is ever withdrawn).
- Reset (M_AXI_ARESETN=0) in any state, including mid-transaction: same clear as init_txn_pulse, plus all AXI outputs low; takes priority over all other inputs.

## Timing

- Reset values: res_ready=1 (state CAPTURE, effective first cycle after reset), AWVALID=WVALID=BREADY=0, AWADDR=0, WDATA=0, WSTRB=4'hF, wb_done=0, wb_error=0.
- res_ready falls the cycle after the M_COL-th accepted beat.
- AWVALID/WVALID rise the cycle after accepted wb_start.
- With always-ready slave and BVALID in the first RESP cycle: 2 cycles per element (WRITE, RESP); the first element's valids appear 1 cycle after wb_start; wb_done rises the cycle after the last B handshake: 2*M_ROW*M_COL cycles after first AWVALID.
- BREADY is low in every state other than RESP; BVALID outside RESP is ignored.

## Test plan

- Reset: hold M_AXI_ARESETN low 3 cycles -> all AXI valids 0, wb_done=0, wb_error=0; res_ready=1 after release.
- Capture: 9 beats, column c row r = 16*r+c, with random 0-2 cycle res_valid gaps -> res_ready drops after 9th accept; 10th beat (0xDEAD) not stored.
- Writeback, base_addr=0x4000_0000, always-ready slave -> 81 writes, AWADDR=0x4000_0000+4*(9r+c), WDATA=16r+c, wb_done high 162 cycles after first AWVALID, wb_error=0.
- Backpressure: AWREADY delayed 3 cycles, WREADY immediate -> WVALID high 1 cycle, AWVALID/AWADDR stable 4 cycles, BREADY rises only after both handshakes; BVALID delayed 5 cycles -> no new AWVALID until B handshake.
- Error: BRESP=2'b10 on element 5 -> wb_error=1 from next cycle, remains 1; all 81 writes still issued; wb_done=1.
- Clears: init_txn_pulse in WRITE -> ignored, transaction completes; in DONE -> wb_done=0, res_ready=1, buffer zero; base_addr=0xFFFF_FFF8 -> element 2 at 0x0000_0000 (wrap); reset during WRITE -> AWVALID=WVALID=0 next cycle.
